// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point encoder and adder datapath:
// field widths, exponent bias, status bit positions and the control state enum.
package fp_pkg;

  localparam int EXP_W  = 6;
  localparam int FRAC_W = 25;
  localparam int BIAS   = 31;

  localparam int ST_ZERO    = 0;
  localparam int ST_NEG     = 1;
  localparam int ST_INEXACT = 2;
  localparam int ST_OVF     = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  // Overflow is never raised: the format's range covers every 32-bit input.
  function automatic logic [3:0] make_status(input logic zero, input logic neg,
                                             input logic inexact);
    logic [3:0] s;
    s             = '0;
    s[ST_ZERO]    = zero;
    s[ST_NEG]     = neg;
    s[ST_INEXACT] = inexact;
    s[ST_OVF]     = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even and field packing of a normalized
// 32-bit magnitude (leading 1 in bit 31) into sign/exponent/fraction.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic [31:0] i_mag,
  input  logic        i_sign,
  input  logic [5:0]  i_lz,
  output logic [31:0] o_data,
  output logic        o_inexact
);

  // Exponent of a value whose leading 1 sat at bit 31 before normalization.
  localparam logic [EXP_W-1:0] EXP_BASE = EXP_W'(BIAS + 31 - FRAC_BITS);

  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [FRAC_W:0]   w_frac_sum;
  logic              w_carry;
  logic [EXP_W-1:0]  w_exp;

  assign w_guard  = i_mag[5];
  assign w_sticky = |i_mag[4:0];
  assign w_inc    = w_guard & (w_sticky | i_mag[6]);

  // The hidden 1 is implicit, so a carry out of the fraction means the
  // significand rolled over to 10.000..., i.e. fraction 0 and exponent + 1.
  assign w_frac_sum = {1'b0, i_mag[30:6]} + {{FRAC_W{1'b0}}, w_inc};
  assign w_carry    = w_frac_sum[FRAC_W];
  assign w_exp      = EXP_BASE - i_lz + {{(EXP_W-1){1'b0}}, w_carry};

  // An unnormalized (all-zero) magnitude packs to the zero word.
  assign o_data    = i_mag[31] ? {i_sign, w_exp, w_frac_sum[FRAC_W-1:0]} : 32'h0;
  assign o_inexact = i_mag[31] & (w_guard | w_sticky);

endmodule

// File: rtl/int_to_fp_encoder.sv
// Signed Q(31-FRAC_BITS).FRAC_BITS to float encoder: iterative one-bit-per-cycle
// normalization followed by a round/pack cycle, valid/ready on both sides.
module int_to_fp_encoder
  import fp_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  state_e      r_state;
  logic        r_sign;
  logic [31:0] r_mag;
  logic [5:0]  r_lz;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_data;
  logic [3:0]  r_status;

  logic [31:0] w_abs;
  logic [31:0] w_packed;
  logic        w_inexact;

  // Two's-complement negate; -2^31 maps onto itself, which is 0x80000000 unsigned.
  assign w_abs = in_data[31] ? (~in_data + 32'd1) : in_data;

  fp_round_pack #(
    .FRAC_BITS(FRAC_BITS)
  ) u_round_pack (
    .i_mag    (r_mag),
    .i_sign   (r_sign),
    .i_lz     (r_lz),
    .o_data   (w_packed),
    .o_inexact(w_inexact)
  );

  // NOTE: every register here is updated with <= so all state changes at the
  // clock edge see the pre-edge values; blocking assignments would chain them.
  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_lz        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_status    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign     <= in_data[31];
            r_mag      <= w_abs;
            r_lz       <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_NORM;
          end
        end
        S_NORM: begin
          // Zero is recognised on the first NORM cycle, one cycle after accept.
          if (r_mag == 32'h0) begin
            r_data      <= '0;
            r_status    <= make_status(1'b1, 1'b0, 1'b0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (!r_mag[31]) begin
            r_mag <= {r_mag[30:0], 1'b0};
            r_lz  <= r_lz + 6'd1;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_data      <= w_packed;
          r_status    <= make_status(1'b0, r_sign, w_inexact);
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign data_out   = r_data;
  assign status_out = r_status;

endmodule

// File: tb/tb_int_to_fp_encoder.sv
// Scoreboard bench for int_to_fp_encoder: two instances (FRAC_BITS 0 and 4),
// an arithmetic reference model, and a negedge monitor that checks every output.
module tb_int_to_fp_encoder;

  typedef struct {
    logic [31:0] din;
    logic [31:0] data;
    logic [3:0]  status;
    int          lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_data;
  logic [1:0]       in_ready;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][31:0] data_out;
  logic [1:0][3:0]  status_out;

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc[2];
  logic [1:0] prev_valid = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    int_to_fp_encoder #(
      .FRAC_BITS(g == 0 ? 0 : 4)
    ) dut (
      .clock_100kHz(clk),
      .reset       (reset),
      .in_valid    (in_valid[g]),
      .in_data     (in_data[g]),
      .in_ready    (in_ready[g]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .data_out    (data_out[g]),
      .status_out  (status_out[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // Reference: locate the leading 1, scale to a 26-bit significand, round the
  // discarded remainder against one half ulp, ties to an even significand.
  function automatic exp_t model(input logic [31:0] d, input int fb);
    exp_t   r;
    longint mag, keep, rem, half;
    int     p, e;
    logic   inexact;
    r.din = d;
    mag   = d[31] ? (64'd4294967296 - longint'(d)) : longint'(d);
    if (mag == 0) begin
      r.data   = 32'h0;
      r.status = 4'b0001;
      r.lat    = 1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 33; i++) if (mag >= (64'd1 << i)) p = i;
    e = 31 + p - fb;
    if (p > 25) begin
      keep = mag >> (p - 25);
      rem  = mag - (keep << (p - 25));
      half = 64'd1 << (p - 26);
      if (rem > half || (rem == half && keep[0])) keep++;
      inexact = (rem != 0);
    end else begin
      keep    = mag << (25 - p);
      inexact = 1'b0;
    end
    if (keep == (64'd1 << 26)) begin
      keep = keep >> 1;
      e++;
    end
    r.data   = {d[31], 6'(e), keep[24:0]};
    r.status = {1'b0, inexact, d[31], 1'b0};
    r.lat    = (31 - p) + 2;
    return r;
  endfunction

  function automatic int sb_size(input int l);
    return (l == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sb_front(input int l);
    return (l == 0) ? sb0[0] : sb1[0];
  endfunction

  function automatic void sb_pop(input int l);
    if (l == 0) void'(sb0.pop_front());
    else        void'(sb1.pop_front());
  endfunction

  function automatic void sb_push(input int l, input exp_t e);
    if (l == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  // Monitor: latency on the rising out_valid, data/status every valid cycle
  // (which also proves stability under backpressure), pop on the take.
  always @(negedge clk) begin
    exp_t e;
    for (int l = 0; l < 2; l++) begin
      if (!reset && in_valid[l] && in_ready[l]) acc_cyc[l] = cyc + 1;
      if (!reset && out_valid[l]) begin
        if (sb_size(l) == 0) begin
          check($sformatf("unexpected_out_l%0d", l), 32'(out_valid[l]), 32'h0);
        end else begin
          e = sb_front(l);
          if (!prev_valid[l])
            check($sformatf("latency_l%0d_%08h", l, e.din), 32'(cyc - acc_cyc[l]), 32'(e.lat));
          check($sformatf("data_l%0d_%08h", l, e.din), data_out[l], e.data);
          check($sformatf("status_l%0d_%08h", l, e.din), 32'(status_out[l]), 32'(e.status));
          if (out_ready[l]) sb_pop(l);
        end
      end
      prev_valid[l] = out_valid[l];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int l, input logic [31:0] d, input bit push);
    int n = 0;
    while (!in_ready[l] && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready[l]) begin
      fail_now($sformatf("in_ready_wait_l%0d", l));
      return;
    end
    if (push) sb_push(l, model(d, (l == 0) ? 0 : 4));
    in_valid[l] = 1'b1;
    in_data[l]  = d;
    tick();
    in_valid[l] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) fail_now("drain");
    tick();
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    // NOTE: inputs are driven with blocking assignments 1 time unit after the
    // edge, so the DUT never races the bench on the sampling edge.
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 2'b11;
    repeat (3) tick();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("rst_in_ready_l%0d", l), 32'(in_ready[l]), 32'h1);
      check($sformatf("rst_out_valid_l%0d", l), 32'(out_valid[l]), 32'h0);
      check($sformatf("rst_data_l%0d", l), data_out[l], 32'h0);
      check($sformatf("rst_status_l%0d", l), 32'(status_out[l]), 32'h0);
    end
    reset = 1'b0;
    tick();

    send(1, 32'h00000018, 1'b1);
    send(0, 32'h00000001, 1'b1);
    send(0, 32'h00000002, 1'b1);
    send(0, 32'hFFFFFFFF, 1'b1);
    send(0, 32'h80000000, 1'b1);
    send(0, 32'h7FFFFFFF, 1'b1);
    send(0, 32'h04000001, 1'b1);
    send(0, 32'h00000000, 1'b1);
    send(1, 32'hFFFFFFF8, 1'b1);
    drain();

    for (int i = 0; i < 60; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = -d;
      send(i % 2, d, 1'b1);
    end
    drain();

    // Backpressure: result held, input blocked and new in_valid ignored.
    out_ready[0] = 1'b0;
    send(0, 32'h00012345, 1'b1);
    n = 0;
    while (!out_valid[0] && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid[0]) fail_now("hold_out_valid_wait");
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'h00000055;
      check("hold_in_ready", 32'(in_ready[0]), 32'h0);
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    check("take_cycle_in_ready", 32'(in_ready[0]), 32'h0);
    tick();
    check("after_take_in_ready", 32'(in_ready[0]), 32'h1);
    drain();

    // Reset in the middle of normalization aborts the conversion.
    send(0, 32'h00000001, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid[0]), 32'h0);
    check("midrst_in_ready", 32'(in_ready[0]), 32'h1);
    check("midrst_data", data_out[0], 32'h0);
    check("midrst_status", 32'(status_out[0]), 32'h0);
    send(0, 32'h00000002, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
